dual_risc_cpu: RTL and testbench

DUAL_RISC_CPU -- requirements
Module: dual_risc_cpu

---
 rtl/risc_opcodes_pkg.sv | 48 ++++
 rtl/risc_core.sv | 126 ++++++++++++
 rtl/dual_risc_cpu.sv | 59 +++++
 tb/tb_dual_risc_cpu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/risc_opcodes_pkg.sv
// rtl/risc_opcodes_pkg.sv - shared opcodes, instruction field positions and core state encodings
// Purpose: common definitions for risc_core and dual_risc_cpu.
//   PC_W / DATA_W        : program counter and data path widths
//   *_HI / *_LO          : instruction field bit positions
//   opcode_t             : instruction opcodes (anything else executes as NOP)
//   state_t              : per-core bus cycle states
//   sext_imm()           : sign-extends the 32-bit immediate of an instruction
package risc_opcodes_pkg;

  localparam int PC_W   = 54;
  localparam int DATA_W = 64;

  localparam int OP_HI  = 63;
  localparam int OP_LO  = 58;
  localparam int RD_HI  = 57;
  localparam int RD_LO  = 55;
  localparam int RS1_HI = 54;
  localparam int RS1_LO = 52;
  localparam int RS2_HI = 51;
  localparam int RS2_LO = 49;
  localparam int IMM_HI = 31;
  localparam int IMM_LO = 0;

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_ADDI = 6'd6,
    OP_JMP  = 6'd7,
    OP_BEQ  = 6'd8,
    OP_HALT = 6'd9
  } opcode_t;

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [DATA_W-1:0] instr);
    return {{(DATA_W-32){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
  endfunction

endpackage

// File: rtl/risc_core.sv
// rtl/risc_core.sv - one fetch-only RISC core with multiplexed address/instruction bus
// Purpose: three-phase core (ADDR -> READ -> EXEC), CPI 3, terminal HALT state.
// Optional scan of the PC when built with `define SCAN_EN.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   data         : inout 64, address out in ADDR, instruction in during READ
//   n_me, n_ale  : active-low memory strobe / address latch enable
//   rnw          : read/not-write, always 1
//   n_oe         : active-low memory output enable
//   test, sdi    : scan mode select, scan data in (used only with SCAN_EN)
//   sdo          : scan data out (PC MSB with SCAN_EN, else 0)
module risc_core
  import risc_opcodes_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 54'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] data,
  output logic              n_me,
  output logic              n_ale,
  output logic              rnw,
  output logic              n_oe,
  input  logic              test,
  input  logic              sdi,
  output logic              sdo
);

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc, pc_nxt;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   regs [0:7];
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic                scan_mode;
  logic                scan_in;

`ifdef SCAN_EN
  assign scan_mode = test;
  assign scan_in   = sdi;
  assign sdo       = rst_n & pc[PC_W-1];
`else
  logic unused_scan_pins;
  assign unused_scan_pins = test ^ sdi;
  assign scan_mode = 1'b0;
  assign scan_in   = 1'b0;
  assign sdo       = 1'b0;
`endif

  // Instruction decode
  logic [5:0]        op;
  logic [2:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic              unused_ir_bits;

  assign op      = ir[OP_HI:OP_LO];
  assign rd      = ir[RD_HI:RD_LO];
  assign rs1     = ir[RS1_HI:RS1_LO];
  assign rs2     = ir[RS2_HI:RS2_LO];
  assign imm     = sext_imm(ir);
  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];
  assign unused_ir_bits = ^ir[RS2_LO-1:IMM_HI+1];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state)
      ST_ADDR: state_nxt = ST_READ;
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: begin
        state_nxt = ST_ADDR;
        pc_nxt    = pc + 54'd1;
        case (op)
          OP_ADD:  begin wr_en = 1'b1; wr_data = rs1_val + rs2_val; end
          OP_SUB:  begin wr_en = 1'b1; wr_data = rs1_val - rs2_val; end
          OP_AND:  begin wr_en = 1'b1; wr_data = rs1_val & rs2_val; end
          OP_OR:   begin wr_en = 1'b1; wr_data = rs1_val | rs2_val; end
          OP_XOR:  begin wr_en = 1'b1; wr_data = rs1_val ^ rs2_val; end
          OP_ADDI: begin wr_en = 1'b1; wr_data = rs1_val + imm; end
          OP_JMP:  pc_nxt = imm[PC_W-1:0];
          OP_BEQ:  if (rs1_val == rs2_val) pc_nxt = pc + imm[PC_W-1:0];
          OP_HALT: begin state_nxt = ST_HALT; pc_nxt = pc; end
          default: ;
        endcase
        // R0 is hardwired to zero
        if (rd == 3'd0) wr_en = 1'b0;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_ADDR;
    endcase
  end

  // Scan keeps a halted core halted; any other state restarts with a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ADDR;
      pc    <= RESET_PC;
      ir    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (scan_mode) begin
      pc <= {pc[PC_W-2:0], scan_in};
      if (state != ST_HALT) state <= ST_ADDR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == ST_READ) ir <= data;
      if (wr_en) regs[rd] <= wr_data;
    end
  end

  // Bus outputs are gated by reset so the pins idle while rst_n is low even
  // though the state register already sits in ADDR.
  logic bus_active, drive_addr;
  assign bus_active = rst_n & ~scan_mode;
  assign drive_addr = bus_active & (state == ST_ADDR);
  assign n_ale      = ~drive_addr;
  assign n_me       = ~(bus_active & ((state == ST_ADDR) | (state == ST_READ)));
  assign n_oe       = ~(bus_active & (state == ST_READ));
  assign rnw        = 1'b1;
  assign data       = drive_addr ? {{(DATA_W-PC_W){1'b0}}, pc} : {DATA_W{1'bz}};

endmodule

// File: rtl/dual_risc_cpu.sv
// rtl/dual_risc_cpu.sv - two independent risc_core instances sharing clock and reset
// Purpose: top level; optional PC scan per core with `define SCAN_EN.
// Ports:
//   Clock, nReset        : system clock, asynchronous active-low reset
//   Data / Data2         : core0 / core1 multiplexed address/instruction bus
//   nME, nALE, RnW, nOE  : core0 bus strobes (suffix 2 for core1)
//   Test, SDI, SDO       : core0 scan pins (suffix 2 for core1)
module dual_risc_cpu
  import risc_opcodes_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 54'd0
) (
  input  logic              Clock,
  input  logic              nReset,
  inout  wire  [DATA_W-1:0] Data,
  inout  wire  [DATA_W-1:0] Data2,
  output logic              nME,
  output logic              nME2,
  output logic              nALE,
  output logic              nALE2,
  output logic              RnW,
  output logic              RnW2,
  output logic              nOE,
  output logic              nOE2,
  input  logic              Test,
  input  logic              Test2,
  input  logic              SDI,
  input  logic              SDI2,
  output logic              SDO,
  output logic              SDO2
);

  risc_core #(.RESET_PC(RESET_PC)) u_core0 (
    .clk   (Clock),
    .rst_n (nReset),
    .data  (Data),
    .n_me  (nME),
    .n_ale (nALE),
    .rnw   (RnW),
    .n_oe  (nOE),
    .test  (Test),
    .sdi   (SDI),
    .sdo   (SDO)
  );

  risc_core #(.RESET_PC(RESET_PC)) u_core1 (
    .clk   (Clock),
    .rst_n (nReset),
    .data  (Data2),
    .n_me  (nME2),
    .n_ale (nALE2),
    .rnw   (RnW2),
    .n_oe  (nOE2),
    .test  (Test2),
    .sdi   (SDI2),
    .sdo   (SDO2)
  );

endmodule

// File: tb/tb_dual_risc_cpu.sv
// tb/tb_dual_risc_cpu.sv - scoreboard bench for dual_risc_cpu
module tb_dual_risc_cpu;

  localparam logic [63:0] PC_MAX = 64'h003F_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  wire [63:0] data0, data1;
  logic n_me0, n_me1, n_ale0, n_ale1, rnw0, rnw1, n_oe0, n_oe1;
  logic test0, test1, sdi0, sdi1, sdo0, sdo1;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int ph [2];
  int last_f [2];
  int fetches [2];
  bit allow_extra [2];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] a0, a1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_risc_cpu dut (
    .Clock(clk), .nReset(rst_n),
    .Data(data0), .Data2(data1),
    .nME(n_me0), .nME2(n_me1),
    .nALE(n_ale0), .nALE2(n_ale1),
    .RnW(rnw0), .RnW2(rnw1),
    .nOE(n_oe0), .nOE2(n_oe1),
    .Test(test0), .Test2(test1),
    .SDI(sdi0), .SDI2(sdi1),
    .SDO(sdo0), .SDO2(sdo1)
  );

  function automatic logic [63:0] enc(input logic [5:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [31:0] imm);
    return {op, rd, rs1, rs2, 17'b0, imm};
  endfunction

  function automatic logic [63:0] rom0(input logic [63:0] a);
    case (a)
      64'd0:   return enc(6, 1, 0, 0, 32'd5);
      64'd1:   return enc(1, 2, 1, 1, 0);
      64'd2:   return enc(6, 3, 0, 0, 32'd10);
      64'd3:   return enc(8, 0, 2, 3, 32'd5);
      64'd8:   return enc(6, 4, 0, 0, 32'hFFFF_FFFF);
      64'd9:   return enc(6, 4, 4, 0, 32'd1);
      64'd10:  return enc(8, 0, 4, 0, 32'd3);
      64'd13:  return enc(2, 5, 2, 1, 0);
      64'd14:  return enc(8, 0, 5, 1, 32'd2);
      64'd16:  return enc(6, 0, 0, 0, 32'd7);
      64'd17:  return enc(8, 0, 0, 7, 32'd3);
      64'd20:  return enc(4, 6, 1, 2, 0);
      64'd21:  return enc(6, 7, 0, 0, 32'd15);
      64'd22:  return enc(8, 0, 6, 7, 32'd2);
      64'd24:  return enc(63, 1, 1, 1, 32'd1);
      64'd25:  return enc(3, 6, 1, 2, 0);
      64'd26:  return enc(8, 0, 6, 0, 32'd2);
      64'd28:  return enc(5, 6, 1, 3, 0);
      64'd29:  return enc(8, 0, 6, 7, 32'd2);
      default: return enc(9, 0, 0, 0, 0);
    endcase
  endfunction

  function automatic logic [63:0] rom1(input logic [63:0] a);
    case (a)
      64'd0:   return enc(0, 0, 0, 0, 0);
      64'd1:   return enc(7, 0, 0, 0, 32'd4);
      64'd2:   return enc(6, 1, 0, 0, 32'd1);
      64'd3:   return enc(8, 0, 0, 0, 32'd1);
      64'd4:   return enc(8, 0, 1, 0, 32'hFFFF_FFFE);
      64'd5:   return enc(7, 0, 0, 0, 32'hFFFF_FFFF);
      PC_MAX:  return enc(0, 0, 0, 0, 0);
      default: return enc(9, 0, 0, 0, 0);
    endcase
  endfunction

  // External address latch and ROMs
  always @(negedge clk) begin
    if (!n_ale0) a0 <= data0;
    if (!n_ale1) a1 <= data1;
  end
  assign data0 = !n_oe0 ? rom0(a0) : 64'bz;
  assign data1 = !n_oe1 ? rom1(a1) : 64'bz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic mon(input int c, input logic nale, input logic nme, input logic noe,
                     input logic tst, input logic [63:0] d);
    logic [63:0] e;
    if (!rst_n || tst) begin
      ph[c] = 0;
      last_f[c] = -1;
      return;
    end
    if (!nale) begin
      fetches[c]++;
      check($sformatf("c%0d_addr_strobes", c), {62'b0, nme, noe}, 64'b01);
      if ((c == 0 && q0.size() > 0) || (c == 1 && q1.size() > 0)) begin
        e = (c == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("c%0d_fetch_addr", c), d, e);
      end else if (!allow_extra[c]) begin
        chk_cnt++;
        $display("FAIL c%0d_unexpected_fetch: got %0h, expected no fetch", c, d);
      end
      if (last_f[c] >= 0) check($sformatf("c%0d_fetch_period", c), 64'(cyc - last_f[c]), 64'd3);
      last_f[c] = cyc;
      ph[c] = 1;
    end else if (ph[c] == 1) begin
      check($sformatf("c%0d_read_strobes", c), {62'b0, nme, noe}, 64'b00);
      ph[c] = 2;
    end else if (ph[c] == 2) begin
      check($sformatf("c%0d_exec_strobes", c), {62'b0, nme, noe}, 64'b11);
      ph[c] = 0;
    end
  endtask

  always @(negedge clk) mon(0, n_ale0, n_me0, n_oe0, test0, data0);
  always @(negedge clk) mon(1, n_ale1, n_me1, n_oe1, test1, data1);

  task automatic push_programs();
    logic [63:0] s0 [21] = '{0, 1, 2, 3, 8, 9, 10, 13, 14, 16, 17, 20, 21, 22, 24, 25, 26, 28, 29, 31, 31};
    logic [63:0] s1 [19] = '{0, 1, 4, 2, 3, 4, 5, PC_MAX, 0, 1, 4, 5, PC_MAX, 0, 1, 4, 5, PC_MAX, 0};
    // word 31 is fetched once; the repeated tail entry is dropped
    for (int i = 0; i < 20; i++) q0.push_back(s0[i]);
    for (int i = 0; i < 19; i++) q1.push_back(s1[i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_c0_pins"}, {59'b0, n_me0, n_ale0, n_oe0, rnw0, sdo0}, 64'b11110);
    check({tag, "_c1_pins"}, {59'b0, n_me1, n_ale1, n_oe1, rnw1, sdo1}, 64'b11110);
  endtask

  task automatic run_and_check(input string tag);
    int f1;
    push_programs();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (90) @(posedge clk);
    #1;
    check({tag, "_q0_left"}, 64'(q0.size()), 64'd0);
    check({tag, "_q1_left"}, 64'(q1.size()), 64'd0);
    f1 = fetches[1];
    for (int i = 0; i < 3; i++) begin
      check({tag, "_c0_halt_idle"}, {61'b0, n_me0, n_ale0, n_oe0}, 64'b111);
      repeat (3) @(posedge clk);
      #1;
    end
    check({tag, "_c1_fetch_rate"}, 64'(fetches[1] - f1), 64'd3);
  endtask

  initial begin
    rst_n = 1'b0;
    test0 = 1'b0; test1 = 1'b0; sdi0 = 1'b0; sdi1 = 1'b0;
    allow_extra[0] = 1'b0;
    allow_extra[1] = 1'b1;
    fetches[0] = 0; fetches[1] = 0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    run_and_check("run1");

`ifdef SCAN_EN
    @(posedge clk); #1;
    test1 = 1'b1; sdi1 = 1'b1;
    repeat (54) @(posedge clk);
    #1 check("scan_sdo", {63'b0, sdo1}, 64'd1);
    allow_extra[1] = 1'b0;
    q1.push_back(PC_MAX);
    q1.push_back(64'd0);
    test1 = 1'b0; sdi1 = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("scan_q1_left", 64'(q1.size()), 64'd0);
    allow_extra[1] = 1'b1;
`endif

    // Reset in the middle of running instructions
    @(posedge clk); #4 rst_n = 1'b0;
    #1 check_idle("midreset");
    repeat (2) @(posedge clk);
    #1 check_idle("midreset_hold");
    run_and_check("run2");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
